// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM state encoding, PC source selects and the default register-address width.
package pipe_pkg;

    localparam int DEF_REG_W = 6;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_ALU = 2'd1;
    localparam logic [1:0] PCSEL_MEM = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// Combinational read-after-write comparator between the ID sources and the
// destinations still in flight; register 0 never creates a dependence.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_W     = DEF_REG_W,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             ex_regwrite,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    output logic             raw
);

    // With write-before-read in the register file, a WB producer is already visible.
    localparam bit CHECK_WB = (WB_BYPASS == 1'b0);

    function automatic logic src_match(input logic [REG_W-1:0] src,
                                       input logic             used,
                                       input logic [REG_W-1:0] rd,
                                       input logic             wr);
        return used && wr && (src == rd) && (src != '0);
    endfunction

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = src_match(id_rs, id_uses_rs, ex_rd, ex_regwrite)
                   | src_match(id_rt, id_uses_rt, ex_rd, ex_regwrite);
    assign mem_hit = src_match(id_rs, id_uses_rs, mem_rd, mem_regwrite)
                   | src_match(id_rt, id_uses_rt, mem_rd, mem_regwrite);
    assign wb_hit  = src_match(id_rs, id_uses_rs, wb_rd, wb_regwrite)
                   | src_match(id_rt, id_uses_rt, wb_rd, wb_regwrite);

    assign raw = ex_hit | mem_hit | (CHECK_WB & wb_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the IF/ID, ID/EX, EX/MEM, MEM/WB buffers:
// stalls on RAW and memory wait, redirects on control transfers resolved in WB.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W     = DEF_REG_W,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ID_RS,
    input  logic [REG_W-1:0] ID_RT,
    input  logic             ID_USES_RS,
    input  logic             ID_USES_RT,
    input  logic [REG_W-1:0] EX_RD,
    input  logic [REG_W-1:0] MEM_RD,
    input  logic [REG_W-1:0] WB_RD,
    input  logic             EX_REGWRITE,
    input  logic             MEM_REGWRITE,
    input  logic             WB_REGWRITE,
    input  logic             WB_JUMP,
    input  logic             WB_JUMPMEM,
    input  logic             WB_BRANCH,
    input  logic             WB_ALU_FLAG,
    input  logic             MEM_BUSY,
    output logic             PC_EN,
    output logic [1:0]       PC_SEL,
    output logic             IF_ID_EN,
    output logic             ID_EX_EN,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic             EX_MEM_FLUSH,
    output logic             MEM_WB_FLUSH,
    output logic             MEM_ABORT,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] REDIR_CNT
);

    state_t state;
    state_t next_state;
    logic   raw;
    logic   redir;
    logic   stall_inc;
    logic   redir_inc;

    hazard_detect #(
        .REG_W    (REG_W),
        .WB_BYPASS(WB_BYPASS)
    ) u_hazard (
        .id_rs       (ID_RS),
        .id_rt       (ID_RT),
        .id_uses_rs  (ID_USES_RS),
        .id_uses_rt  (ID_USES_RT),
        .ex_rd       (EX_RD),
        .mem_rd      (MEM_RD),
        .wb_rd       (WB_RD),
        .ex_regwrite (EX_REGWRITE),
        .mem_regwrite(MEM_REGWRITE),
        .wb_regwrite (WB_REGWRITE),
        .raw         (raw)
    );

    assign redir = WB_JUMP | WB_JUMPMEM | (WB_BRANCH & WB_ALU_FLAG);
    assign STATE = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            STALL_CNT <= '0;
            REDIR_CNT <= '0;
        end else begin
            state <= next_state;
            if (stall_inc && (STALL_CNT != '1))
                STALL_CNT <= STALL_CNT + CNT_W'(1);
            if (redir_inc && (REDIR_CNT != '1))
                REDIR_CNT <= REDIR_CNT + CNT_W'(1);
        end
    end

    // The all-zero default is the full-stall pattern used by MEM_WAIT and a busy RUN.
    always_comb begin
        next_state   = state;
        PC_EN        = 1'b0;
        PC_SEL       = PCSEL_SEQ;
        IF_ID_EN     = 1'b0;
        ID_EX_EN     = 1'b0;
        EX_MEM_EN    = 1'b0;
        MEM_WB_EN    = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_FLUSH  = 1'b0;
        EX_MEM_FLUSH = 1'b0;
        MEM_WB_FLUSH = 1'b0;
        MEM_ABORT    = 1'b0;
        stall_inc    = 1'b0;
        redir_inc    = 1'b0;

        case (state)
            INIT: begin
                IF_ID_FLUSH  = 1'b1;
                ID_EX_FLUSH  = 1'b1;
                EX_MEM_FLUSH = 1'b1;
                MEM_WB_FLUSH = 1'b1;
                MEM_ABORT    = 1'b1;
                next_state   = RUN;
            end
            // A wait that ends behaves as RUN that cycle, except WB is frozen so no redirect.
            RUN, MEM_WAIT: begin
                next_state = RUN;
                if (state == MEM_WAIT && MEM_BUSY) begin
                    next_state = MEM_WAIT;
                    stall_inc  = 1'b1;
                end else if (state == RUN && redir) begin
                    PC_EN        = 1'b1;
                    PC_SEL       = WB_JUMPMEM ? PCSEL_MEM : PCSEL_ALU;
                    IF_ID_EN     = 1'b1;
                    ID_EX_EN     = 1'b1;
                    EX_MEM_EN    = 1'b1;
                    MEM_WB_EN    = 1'b1;
                    IF_ID_FLUSH  = 1'b1;
                    ID_EX_FLUSH  = 1'b1;
                    EX_MEM_FLUSH = 1'b1;
                    MEM_WB_FLUSH = 1'b1;
                    MEM_ABORT    = MEM_BUSY;
                    next_state   = REDIRECT;
                    redir_inc    = 1'b1;
                end else if (MEM_BUSY) begin
                    next_state = MEM_WAIT;
                    stall_inc  = 1'b1;
                end else if (raw) begin
                    ID_EX_EN    = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                    EX_MEM_EN   = 1'b1;
                    MEM_WB_EN   = 1'b1;
                    stall_inc   = 1'b1;
                end else begin
                    PC_EN     = 1'b1;
                    IF_ID_EN  = 1'b1;
                    ID_EX_EN  = 1'b1;
                    EX_MEM_EN = 1'b1;
                    MEM_WB_EN = 1'b1;
                end
            end
            REDIRECT: begin
                PC_EN      = 1'b1;
                IF_ID_EN   = 1'b1;
                ID_EX_EN   = 1'b1;
                EX_MEM_EN  = 1'b1;
                MEM_WB_EN  = 1'b1;
                next_state = RUN;
            end
            default: next_state = INIT;
        endcase
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl: each record gives the inputs for one
// cycle and the outputs/state/counters expected before that cycle's posedge.
module tb_pipeline_ctrl;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [5:0]  rs;
        logic        urs;
        logic [5:0]  rt;
        logic        urt;
        logic [5:0]  exrd;
        logic        exw;
        logic [5:0]  memrd;
        logic        memw;
        logic [5:0]  wbrd;
        logic        wbw;
        logic [4:0]  ctl;
        logic [1:0]  st;
        logic        pe;
        logic [1:0]  sel;
        logic [3:0]  en;
        logic [3:0]  fl;
        logic        ab;
        logic [15:0] sc;
        logic [15:0] rc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs, id_uses_rt, ex_regwrite, mem_regwrite, wb_regwrite;
    logic        wb_jump, wb_jumpmem, wb_branch, wb_alu_flag, mem_busy;
    logic        pc_en, mem_abort;
    logic [1:0]  pc_sel, state;
    logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [15:0] stall_cnt, redir_cnt;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    pipeline_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ID_RS       (id_rs),
        .ID_RT       (id_rt),
        .ID_USES_RS  (id_uses_rs),
        .ID_USES_RT  (id_uses_rt),
        .EX_RD       (ex_rd),
        .MEM_RD      (mem_rd),
        .WB_RD       (wb_rd),
        .EX_REGWRITE (ex_regwrite),
        .MEM_REGWRITE(mem_regwrite),
        .WB_REGWRITE (wb_regwrite),
        .WB_JUMP     (wb_jump),
        .WB_JUMPMEM  (wb_jumpmem),
        .WB_BRANCH   (wb_branch),
        .WB_ALU_FLAG (wb_alu_flag),
        .MEM_BUSY    (mem_busy),
        .PC_EN       (pc_en),
        .PC_SEL      (pc_sel),
        .IF_ID_EN    (if_id_en),
        .ID_EX_EN    (id_ex_en),
        .EX_MEM_EN   (ex_mem_en),
        .MEM_WB_EN   (mem_wb_en),
        .IF_ID_FLUSH (if_id_flush),
        .ID_EX_FLUSH (id_ex_flush),
        .EX_MEM_FLUSH(ex_mem_flush),
        .MEM_WB_FLUSH(mem_wb_flush),
        .MEM_ABORT   (mem_abort),
        .STATE       (state),
        .STALL_CNT   (stall_cnt),
        .REDIR_CNT   (redir_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl packs {jump, jumpmem, branch, alu_flag, mem_busy}; en/fl pack IF_ID..MEM_WB.
    function automatic vec_t mk(input string name, input logic rst,
                                input logic [5:0] rs, input logic urs,
                                input logic [5:0] rt, input logic urt,
                                input logic [5:0] exrd, input logic exw,
                                input logic [5:0] memrd, input logic memw,
                                input logic [5:0] wbrd, input logic wbw,
                                input logic [4:0] ctl, input logic [1:0] st,
                                input logic pe, input logic [1:0] sel,
                                input logic [3:0] en, input logic [3:0] fl,
                                input logic ab, input logic [15:0] sc,
                                input logic [15:0] rc);
        vec_t v;
        v.name = name; v.rst_n = rst;
        v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
        v.exrd = exrd; v.exw = exw; v.memrd = memrd; v.memw = memw;
        v.wbrd = wbrd; v.wbw = wbw; v.ctl = ctl;
        v.st = st; v.pe = pe; v.sel = sel; v.en = en; v.fl = fl; v.ab = ab;
        v.sc = sc; v.rc = rc;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst_n        = v.rst_n;
        id_rs        = v.rs;
        id_uses_rs   = v.urs;
        id_rt        = v.rt;
        id_uses_rt   = v.urt;
        ex_rd        = v.exrd;
        ex_regwrite  = v.exw;
        mem_rd       = v.memrd;
        mem_regwrite = v.memw;
        wb_rd        = v.wbrd;
        wb_regwrite  = v.wbw;
        {wb_jump, wb_jumpmem, wb_branch, wb_alu_flag, mem_busy} = v.ctl;
    endtask

    task automatic checkOutput(input vec_t v);
        logic [3:0] en_act;
        logic [3:0] fl_act;
        en_act = {if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
        fl_act = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
        n_vec++;
        if (state !== v.st || pc_en !== v.pe || pc_sel !== v.sel || en_act !== v.en ||
            fl_act !== v.fl || mem_abort !== v.ab || stall_cnt !== v.sc || redir_cnt !== v.rc) begin
            n_bad++;
            $display("[TB] FAIL %s: got st=%0d pc_en=%b sel=%0d en=%b fl=%b abort=%b stall=%0d redir=%0d, expected st=%0d pc_en=%b sel=%0d en=%b fl=%b abort=%b stall=%0d redir=%0d",
                     v.name, state, pc_en, pc_sel, en_act, fl_act, mem_abort, stall_cnt, redir_cnt,
                     v.st, v.pe, v.sel, v.en, v.fl, v.ab, v.sc, v.rc);
        end
    endtask

    initial begin
        vec_t v;

        //          name              rst rs urs rt urt exrd w memrd w wbrd w ctl       st pe sel en       fl       ab sc rc
        vecs.push_back(mk("reset_hold",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 4'b0000, 4'b1111, 1, 0, 0));
        vecs.push_back(mk("init",           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 4'b0000, 4'b1111, 1, 0, 0));
        vecs.push_back(mk("run_idle",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 4'b1111, 4'b0000, 0, 0, 0));
        vecs.push_back(mk("raw_ex",         1, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 5'b00000, 1, 0, 0, 4'b0111, 4'b0100, 0, 0, 0));
        vecs.push_back(mk("raw_mem",        1, 5, 1, 0, 0, 0, 0, 5, 1, 0, 0, 5'b00000, 1, 0, 0, 4'b0111, 4'b0100, 0, 1, 0));
        vecs.push_back(mk("after_raw",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 4'b1111, 4'b0000, 0, 2, 0));
        vecs.push_back(mk("reg0_no_haz",    1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 4'b1111, 4'b0000, 0, 2, 0));
        vecs.push_back(mk("wb_bypass",      1, 5, 1, 0, 0, 0, 0, 0, 0, 5, 1, 5'b00000, 1, 1, 0, 4'b1111, 4'b0000, 0, 2, 0));
        vecs.push_back(mk("rt_unused",      1, 0, 0, 7, 0, 7, 1, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 4'b1111, 4'b0000, 0, 2, 0));
        vecs.push_back(mk("raw_rt_mem",     1, 0, 0, 9, 1, 0, 0, 9, 1, 0, 0, 5'b00000, 1, 0, 0, 4'b0111, 4'b0100, 0, 2, 0));
        vecs.push_back(mk("br_taken",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 1, 1, 1, 4'b1111, 4'b1111, 0, 3, 0));
        vecs.push_back(mk("redirect",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 3, 1, 0, 4'b1111, 4'b0000, 0, 3, 1));
        vecs.push_back(mk("after_redir",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 4'b1111, 4'b0000, 0, 3, 1));
        vecs.push_back(mk("br_not_taken",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 1, 1, 0, 4'b1111, 4'b0000, 0, 3, 1));
        vecs.push_back(mk("jmem_over_busy", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 1, 1, 2, 4'b1111, 4'b1111, 1, 3, 1));
        vecs.push_back(mk("redirect2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 3, 1, 0, 4'b1111, 4'b0000, 0, 3, 2));
        vecs.push_back(mk("busy1",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 1, 0, 0, 4'b0000, 4'b0000, 0, 3, 2));
        vecs.push_back(mk("busy2",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 2, 0, 0, 4'b0000, 4'b0000, 0, 4, 2));
        vecs.push_back(mk("busy3",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 2, 0, 0, 4'b0000, 4'b0000, 0, 5, 2));
        vecs.push_back(mk("busy_done",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2, 1, 0, 4'b1111, 4'b0000, 0, 6, 2));
        vecs.push_back(mk("run_after_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 4'b1111, 4'b0000, 0, 6, 2));
        vecs.push_back(mk("busy_again",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 1, 0, 0, 4'b0000, 4'b0000, 0, 6, 2));
        vecs.push_back(mk("reset_in_wait",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 2, 0, 0, 4'b0000, 4'b0000, 0, 7, 2));
        vecs.push_back(mk("init_again",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 4'b0000, 4'b1111, 1, 0, 0));
        vecs.push_back(mk("run2",           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 4'b1111, 4'b0000, 0, 0, 0));
        vecs.push_back(mk("jump",           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000, 1, 1, 1, 4'b1111, 4'b1111, 0, 0, 0));
        vecs.push_back(mk("redirect3",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 3, 1, 0, 4'b1111, 4'b0000, 0, 0, 1));
        vecs.push_back(mk("run3",           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 4'b1111, 4'b0000, 0, 0, 1));

        applyStimulus(vecs[0]);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i]);
            @(posedge clk);
            #1;
        end

        // Long memory wait drives STALL_CNT to all-ones, then it must hold there.
        v = mk("sat_reach", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 2, 0, 0, 4'b0000, 4'b0000, 0, 16'hFFFF, 1);
        applyStimulus(v);
        repeat (65535) @(posedge clk);
        @(negedge clk);
        checkOutput(v);
        v.name = "sat_hold";
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        #1;
        v = mk("sat_release", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2, 1, 0, 4'b1111, 4'b0000, 0, 16'hFFFF, 1);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        #1;
        v = mk("sat_run", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 0, 4'b1111, 4'b0000, 0, 16'hFFFF, 1);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 4-buffer pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-buffer enable/flush, PC enable and PC source select, from:
  - register-dependence checks,
  - memory wait,
  - control-transfer resolution in WB.
- Keeps saturating stall/redirect counters for performance debug.

Parameters:
- REG_W, 6, register-address width (matches RD fields in the buffers).
- WB_BYPASS, 1, 1 = register file writes before it reads in the same cycle, so a WB-stage match is not a hazard.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; state and counters update on posedge (buffers sample on negedge).
- rst_n  in  1  synchronous active-low reset.
- ID_RS, ID_RT  in  REG_W  source registers of the instruction in ID.
- ID_USES_RS, ID_USES_RT  in  1  source actually read.
- EX_RD, MEM_RD, WB_RD  in  REG_W  destination in EX, MEM, WB.
- EX_REGWRITE, MEM_REGWRITE, WB_REGWRITE  in  1  stage will write RD.
- WB_JUMP, WB_JUMPMEM, WB_BRANCH, WB_ALU_FLAG  in  1  control flags at MEM/WB output.
- MEM_BUSY  in  1  data memory not ready.
- PC_EN  out  1  PC update enable.
- PC_SEL  out  2  0 = PC+1, 1 = ALU_S (jump/branch target), 2 = DATA (memory-indirect jump).
- IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1  buffer load enables.
- IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH  out  1  load a bubble (all control bits 0).
- MEM_ABORT  out  1  cancel the in-flight memory access.
- STATE  out  2  current FSM state.
- STALL_CNT, REDIR_CNT  out  CNT_W  saturating counters.

Behaviour:
- Timing model:
  - State and counters are registered on posedge clk.
  - All other outputs are combinational from state and inputs, valid before the following negedge.
- Register 0 is never a hazard.
- Reset (rst_n = 0 at a posedge):
  - State goes to INIT; counters clear to 0.
  - While in INIT, outputs are: all EN = 0, all FLUSH = 1, PC_EN = 0, PC_SEL = 0, MEM_ABORT = 1.
  - Reset asserted mid-stall or mid-wait overrides everything at the next posedge.
- INIT: one cycle, then RUN unconditionally.
- Taken control transfer: redir = WB_JUMP | WB_JUMPMEM | (WB_BRANCH & WB_ALU_FLAG).
  - PC_SEL = 2 if WB_JUMPMEM, else 1 if WB_JUMP or branch taken, else 0.
  - WB_JUMPMEM has priority over WB_JUMP.
- Hazard: raw = any used source equals a RD with REGWRITE set, in EX or MEM, or in WB when WB_BYPASS = 0.
- RUN priority: redir > MEM_BUSY > raw.
  - redir:
    - Outputs: PC_EN = 1; all four FLUSH = 1; MEM_ABORT = MEM_BUSY.
    - Next state REDIRECT; REDIR_CNT += 1.
  - MEM_BUSY:
    - Outputs: all EN = 0, PC_EN = 0.
    - Next state MEM_WAIT; STALL_CNT += 1.
  - raw:
    - Outputs: PC_EN = 0, IF_ID_EN = 0, ID_EX_FLUSH = 1, EX_MEM_EN = MEM_WB_EN = 1.
    - Stay in RUN; STALL_CNT += 1.
    - Repeats each cycle until the producer leaves the hazard window (at most 2 cycles with bypass, 3 without).
  - none: all EN = 1, PC_EN = 1, PC_SEL = 0.
- MEM_WAIT:
  - Outputs: all EN = 0, PC_EN = 0.
  - Each cycle with MEM_BUSY = 1: stay; STALL_CNT += 1.
  - MEM_BUSY = 0: return to RUN and evaluate RUN rules in that cycle's combinational outputs.
  - redir is not evaluated here; the WB contents are frozen.
- REDIRECT (one cycle):
  - The pipeline holds only bubbles, so flags are ignored.
  - Outputs: all EN = 1, PC_EN = 1, PC_SEL = 0.
  - Next state RUN.
- Counters saturate at all-ones and never wrap.
- An EN = 1 together with FLUSH = 1 on the same buffer means load a bubble; FLUSH dominates.

Decomposition:
- Shared package pipe_pkg:
  - state encoding: INIT = 0, RUN = 1, MEM_WAIT = 2, REDIRECT = 3;
  - PC_SEL constants PCSEL_SEQ = 0, PCSEL_ALU = 1, PCSEL_MEM = 2;
  - REG_W default.
- One natural sub-module: hazard_detect (combinational comparator producing raw).
- Counters stay inline.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles, release -> one cycle of INIT (all FLUSH = 1, PC_EN = 0), then RUN with all EN = 1, both counters = 0.
- RAW stall: ID_RS = 5, ID_USES_RS = 1, EX_RD = 5, EX_REGWRITE = 1 for one cycle, then MEM_RD = 5 the next -> 2 cycles of PC_EN = 0, ID_EX_FLUSH = 1, STALL_CNT = 2.
- Register-0 and bypass cases:
  - EX_RD = 0 matching ID_RS = 0 -> no stall.
  - With WB_BYPASS = 1, WB_RD = 5 matching ID_RS = 5 -> no stall.
- Branch: WB_BRANCH = 1, WB_ALU_FLAG = 1 -> PC_SEL = 1, all FLUSH = 1, REDIR_CNT = 1, next cycle STATE = 3, then RUN.
- Branch not taken: WB_BRANCH = 1, WB_ALU_FLAG = 0 -> PC_SEL = 0, no flush.
- Redirect over memory wait: WB_JUMPMEM = 1 and MEM_BUSY = 1 in the same cycle -> PC_SEL = 2, MEM_ABORT = 1, REDIRECT (not MEM_WAIT).
- Memory wait: MEM_BUSY = 1 for 3 cycles -> all EN = 0 for 3 cycles, STALL_CNT = 3.
- Reset asserted during MEM_WAIT -> INIT next cycle, counters = 0.
- Counter saturation: preload to all-ones via forced stall, one more stall -> STALL_CNT stays all-ones.
